// File: rtl/scan_dec_pkg.sv
// Shared types and helpers for the scan decoder.
// Scan phases, mode encodings and the one-cold pattern generator.
package scan_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANKING,
    DRIVE
  } scan_state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic logic [31:0] onecold(
    input logic [4:0] s
  );
    return ~(32'd1 << s);
  endfunction

endpackage

// File: rtl/onecold_dec.sv
// Combinational N-to-2**N decoder with active-low outputs.
// An active-low enable forces every output inactive.
module onecold_dec
  import scan_dec_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en_n,
  output logic [2**SEL_W-1:0] d_n
);

  localparam int OUT_W = 2**SEL_W;

  assign d_n = en_n ? '1 : OUT_W'(onecold(5'(sel)));

endmodule

// File: rtl/scan_decoder_dl.sv
// Registered one-cold decoder with direct and auto-scan modes.
// Scan steps dwell DWELL cycles, the first BLANK of them blanked.
module scan_decoder_dl
  import scan_dec_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4,
  parameter int BLANK = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_n,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                hold,
  output logic [2**SEL_W-1:0] d_n,
  output logic [SEL_W-1:0]    idx,
  output logic                wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CW    = $clog2(DWELL + 1);

  localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = '1;

  scan_state_e      state_q, state_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] d_n_q, d_n_d;
  logic             wrap_q, wrap_d;

  logic             dis, dir, ld, hld, adv;
  logic             scan_on;
  logic             dec_en_n;
  logic [OUT_W-1:0] dec_out;

  // A scan resumes only from a live scan phase; otherwise it reloads.
  assign scan_on = !en_n && (mode == MODE_SCAN);
  assign dis = en_n;
  assign dir = !en_n && (mode == MODE_DIRECT);
  assign ld  = scan_on &&
               ((mode_q == MODE_DIRECT) || (state_q == IDLE));
  assign hld = scan_on && !ld && hold;
  assign adv = scan_on && !ld && !hold;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    unique case (1'b1)
      dis: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      dir: begin
        mode_d  = MODE_DIRECT;
        cnt_d   = '0;
        idx_d   = sel;
        state_d = IDLE;
      end
      ld: begin
        mode_d = MODE_SCAN;
        cnt_d  = '0;
        idx_d  = sel;
      end
      hld: ;
      adv: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    if (ld || adv) begin
      state_d = (BLANK > int'(cnt_d)) ? BLANKING : DRIVE;
    end
  end

  assign dec_en_n = en_n || (state_d == BLANKING);

  onecold_dec #(
    .SEL_W(SEL_W)
  ) u_dec (
    .sel (idx_d),
    .en_n(dec_en_n),
    .d_n (dec_out)
  );

  assign d_n_d = hld ? d_n_q : dec_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_DIRECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      d_n_q   <= '1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      d_n_q   <= d_n_d;
      wrap_q  <= wrap_d;
    end
  end

  assign d_n  = d_n_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder_dl.sv
// Directed bench for scan_decoder_dl plus small-parameter variants.
// Expected values are worked out by hand from the decode rules.
module tb_scan_decoder_dl;

  logic       clk = 1'b0;
  logic       rst, en_n, mode, hold;
  logic [1:0] sel;
  logic [3:0] d_n;
  logic [1:0] idx;
  logic       wrap;

  logic       s_rst, s_mode;
  logic       sel1;
  logic [2:0] sel3;
  logic [1:0] d1;
  logic       idx1, wrap1;
  logic [7:0] d3;
  logic [2:0] idx3;
  logic       wrap3;

  int n_chk = 0;
  int n_err = 0;
  int wraps, wraps1, wraps3;
  logic [3:0] ed;
  logic [1:0] ei;
  logic [1:0] ed1;
  logic [7:0] ed3;

  always #5 clk = ~clk;

  scan_decoder_dl #(.SEL_W(2), .DWELL(4), .BLANK(1)) u_main (
    .clk(clk), .rst(rst), .en_n(en_n), .mode(mode),
    .sel(sel), .hold(hold), .d_n(d_n), .idx(idx), .wrap(wrap)
  );

  scan_decoder_dl #(.SEL_W(1), .DWELL(1), .BLANK(0)) u_w1 (
    .clk(clk), .rst(s_rst), .en_n(1'b0), .mode(s_mode),
    .sel(sel1), .hold(1'b0), .d_n(d1), .idx(idx1), .wrap(wrap1)
  );

  scan_decoder_dl #(.SEL_W(3), .DWELL(1), .BLANK(0)) u_w3 (
    .clk(clk), .rst(s_rst), .en_n(1'b0), .mode(s_mode),
    .sel(sel3), .hold(1'b0), .d_n(d3), .idx(idx3), .wrap(wrap3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_n = 1'b0; mode = 1'b0; sel = 2'd0; hold = 1'b0;
    s_rst = 1'b1; s_mode = 1'b0; sel1 = 1'b0; sel3 = 3'd0;
    step();
    chk("rst_dn", 32'(d_n), 32'hf);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    rst = 1'b0;
    sel = 2'd0; step(); chk("dir0", 32'(d_n), 32'he);
    sel = 2'd1; step(); chk("dir1", 32'(d_n), 32'hd);
    sel = 2'd2; step(); chk("dir2", 32'(d_n), 32'hb);
    sel = 2'd3; step(); chk("dir3", 32'(d_n), 32'h7);
    chk("dir3_idx", 32'(idx), 32'd3);

    en_n = 1'b1; sel = 2'd1; step();
    chk("dis_dn", 32'(d_n), 32'hf);
    chk("dis_idx", 32'(idx), 32'd3);
    chk("dis_wrap", 32'(wrap), 32'd0);
    en_n = 1'b0; sel = 2'd2; step();
    chk("en_dn", 32'(d_n), 32'hb);
    chk("en_idx", 32'(idx), 32'd2);

    mode = 1'b1; sel = 2'd3; step();
    chk("ld_idx", 32'(idx), 32'd3);
    chk("ld_dn", 32'(d_n), 32'hf);
    chk("ld_wrap", 32'(wrap), 32'd0);
    sel = 2'd0;
    wraps = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      ei = 2'((3 + k / 4) % 4);
      ed = (k % 4 == 0) ? 4'hf : ~(4'b0001 << ei);
      if (wrap) wraps++;
      chk($sformatf("scan_idx%0d", k), 32'(idx), 32'(ei));
      chk($sformatf("scan_dn%0d", k), 32'(d_n), 32'(ed));
      chk($sformatf("scan_wrap%0d", k), 32'(wrap), 32'(k == 4));
    end
    chk("scan_wraps", 32'(wraps), 32'd1);

    for (int k = 16; k < 27; k++) step();
    chk("pre_hold_idx", 32'(idx), 32'd1);
    chk("pre_hold_dn", 32'(d_n), 32'hd);

    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hold_idx%0d", k), 32'(idx), 32'd1);
      chk($sformatf("hold_dn%0d", k), 32'(d_n), 32'hd);
      chk($sformatf("hold_wrap%0d", k), 32'(wrap), 32'd0);
    end
    hold = 1'b0;
    step();
    chk("rel_idx", 32'(idx), 32'd1);
    chk("rel_dn", 32'(d_n), 32'hd);
    step();
    chk("rel_next_idx", 32'(idx), 32'd2);
    chk("rel_next_dn", 32'(d_n), 32'hf);

    rst = 1'b1; step();
    chk("mrst_dn", 32'(d_n), 32'hf);
    chk("mrst_idx", 32'(idx), 32'd0);
    chk("mrst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0; sel = 2'd1; step();
    chk("rld_idx", 32'(idx), 32'd1);
    chk("rld_dn", 32'(d_n), 32'hf);
    step();
    chk("rld_drive", 32'(d_n), 32'hd);

    mode = 1'b0; sel = 2'd3; step();
    chk("back_dir", 32'(d_n), 32'h7);
    mode = 1'b1; sel = 2'd0; step();
    chk("ld30_idx", 32'(idx), 32'd0);
    chk("ld30_wrap", 32'(wrap), 32'd0);
    mode = 1'b0; sel = 2'd1; step();
    chk("m10_dn", 32'(d_n), 32'hd);
    chk("m10_idx", 32'(idx), 32'd1);
    hold = 1'b1; sel = 2'd2; step();
    chk("dir_hold", 32'(d_n), 32'hb);
    hold = 1'b0;

    s_rst = 1'b0; s_mode = 1'b1; step();
    chk("w1_ld", 32'(d1), 32'h2);
    chk("w3_ld", 32'(d3), 32'hfe);
    wraps1 = 0; wraps3 = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      ed1 = ~(2'b01 << (k % 2));
      ed3 = ~(8'b0000_0001 << (k % 8));
      if (wrap1) wraps1++;
      if (wrap3) wraps3++;
      chk($sformatf("w1_dn%0d", k), 32'(d1), 32'(ed1));
      chk($sformatf("w1_zeros%0d", k), 32'($countones(~d1)), 32'd1);
      chk($sformatf("w1_wrap%0d", k), 32'(wrap1), 32'(k % 2 == 0));
      chk($sformatf("w3_dn%0d", k), 32'(d3), 32'(ed3));
      chk($sformatf("w3_zeros%0d", k), 32'($countones(~d3)), 32'd1);
      chk($sformatf("w3_wrap%0d", k), 32'(wrap3), 32'(k % 8 == 0));
    end
    chk("w1_wraps", 32'(wraps1), 32'd12);
    chk("w3_wraps", 32'(wraps3), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scan_decoder_dl.md
SCAN_DECODER_DL -- requirements
Module: scan_decoder_dl

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2, meaning the select width; the output count is OUT_W = 2**SEL_W; legal range is 1..5.
REQ-002 The block SHALL have parameter DWELL, default 4, meaning the number of clock cycles per scan step; legal range is 1..65535.
REQ-003 The block SHALL have parameter BLANK, default 0, meaning the number of all-inactive cycles at the start of each scan step; legal range is 0..DWELL-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en_n, input, 1 bit: active-low enable; 1 forces all outputs inactive.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects direct decode, 1 selects auto-scan.
REQ-008 The block SHALL have port sel, input, SEL_W bits: the direct-decode index and the scan start index.
REQ-009 The block SHALL have port hold, input, 1 bit: freezes scan progress while 1.
REQ-010 The block SHALL have port d_n, output, OUT_W bits: registered one-cold outputs, active-low.
REQ-011 The block SHALL have port idx, output, SEL_W bits: the registered current index.
REQ-012 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse when the scan wraps from OUT_W-1 to 0.

Function
REQ-013 In direct mode with en_n=0, the block SHALL register d_n = ~(1 << sel) and idx = sel, with one-cycle latency.
REQ-014 With en_n=1, d_n SHALL be all ones on the next cycle; the dwell counter SHALL clear; idx SHALL retain its value; wrap SHALL be 0.
REQ-015 At most one bit of d_n SHALL be 0 in any cycle.
REQ-016 The scan SHALL use states IDLE (direct mode or disabled), BLANKING (cnt < BLANK) and DRIVE (cnt >= BLANK).
REQ-017 In auto-scan, dwell counter cnt SHALL count 0..DWELL-1; on terminal count it SHALL return to 0 and idx SHALL advance by 1 modulo OUT_W.
REQ-018 During BLANKING, d_n SHALL be all ones; during DRIVE, d_n SHALL be ~(1 << idx).
REQ-019 wrap SHALL be 1 for exactly the cycle in which idx is registered 0 after being OUT_W-1 through scan advance only; a load from sel SHALL never assert wrap.
REQ-020 On a mode 0->1 transition (registered mode was 0, input is 1), idx SHALL load sel and cnt SHALL clear; scan then proceeds from that index.
REQ-021 On a mode 1->0 transition, the block SHALL return to direct behaviour on the next cycle and cnt SHALL clear.
REQ-022 While hold=1 in auto-scan, cnt, idx and d_n SHALL keep their values and wrap SHALL be 0; hold SHALL have no effect in direct mode.
REQ-023 Priority SHALL be rst > en_n > mode transition load > hold > count advance.
REQ-024 When DWELL=1 and BLANK=0, idx SHALL advance every cycle with no inactive cycles.
REQ-025 When SEL_W=1, the block SHALL behave as a 1-to-2 decoder with wrap at idx 1->0.

Reset
REQ-026 While rst=1 on a clock edge, the block SHALL set d_n to all ones, idx to 0, cnt to 0, wrap to 0 and the registered mode to 0, regardless of en_n.
REQ-027 A reset asserted mid-scan SHALL abandon the current step; after release, auto-scan SHALL start with a mode 0->1 load from sel.

Structure
REQ-028 Package scan_dec_pkg SHALL hold the state typedef (IDLE, BLANKING, DRIVE), the mode constants MODE_DIRECT/MODE_SCAN and a one-cold helper function.
REQ-029 Combinational sub-module onecold_dec (SEL_W in, 2**SEL_W active-low out, active-low enable) SHALL generate d_n's next value; all registers SHALL reside in scan_decoder_dl.
REQ-030 The dwell counter width SHALL be $clog2(DWELL+1).

Verification
REQ-031 Direct: SEL_W=2, en_n=0, mode=0, sel=0..3 -> d_n = 1110, 1101, 1011, 0111, each one cycle after its sel.
REQ-032 Enable: en_n=1 with any sel -> d_n=1111 next cycle; en_n=0 with sel=2 -> d_n=1011 the following cycle.
REQ-033 Scan: DWELL=4, BLANK=1, start sel=3 -> idx 3,0,1,2 each for 4 cycles with first cycle d_n=1111; wrap pulses once at 3->0.
REQ-034 Hold: assert hold for 5 cycles at idx=1, cnt=2 -> outputs frozen; after release, 1 more DRIVE cycle then idx=2.
REQ-035 Reset mid-scan: rst at idx=2 -> d_n=1111, idx=0, wrap=0 next cycle; after release with mode=1 and sel=1, scan starts at idx 1.
REQ-036 Parameter sweep: SEL_W=1,3 and DWELL=1,BLANK=0 -> at most one zero in d_n every cycle; wrap period = OUT_W*DWELL cycles.
